// File: rtl/fetch_stage_pkg.sv
// Core-wide constants shared by the fetch stage and the future data-side memory stage.
// Also provides the small PC-alignment helper used on redirects.
package fetch_stage_pkg;

    localparam int              XLEN        = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;
    localparam logic [XLEN-1:0] START_ADDR  = 32'h0100_0000;
    localparam logic [XLEN-1:0] NOP_INSTR   = 32'h0000_0013;

    // Execute traps misaligned targets, so the fetch side simply drops the low bits.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~(INSTR_BYTES - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_stage_range_check.sv
// Combinational window check: is an address inside [BASE_ADDR, BASE_ADDR + SIZE_BYTES)?
// Kept standalone so the data-side memory stage can reuse it.
module fetch_range_check
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] BASE_ADDR  = START_ADDR,
    parameter logic [XLEN-1:0] SIZE_BYTES = 32'd4096
) (
    input  logic [XLEN-1:0] address,
    output logic            in_range
);

    logic [XLEN-1:0] offset;

    // Offset wraps below BASE_ADDR; the first term rejects that case.
    assign offset   = address - BASE_ADDR;
    assign in_range = (address >= BASE_ADDR) && (offset < SIZE_BYTES);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the synchronous instruction memory and hands
// {pc, instr, fault} to decode over valid/ready; execute redirects take priority.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] START_ADDR_P = START_ADDR,
    parameter logic [XLEN-1:0] MEM_BYTES    = 32'd4096,
    parameter logic [XLEN-1:0] NOP_INSTR_P  = NOP_INSTR
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            if_fault,
    output logic [XLEN-1:0] imem_address,
    output logic            imem_enable,
    output logic            imem_read_write,
    output logic [XLEN-1:0] imem_data_in,
    input  logic [XLEN-1:0] imem_data_out
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] out_pc_q,   out_pc_d;
    logic            inflight_q, inflight_d;
    logic            out_fault_q, out_fault_d;
    logic            in_range;
    logic            issue;

    fetch_range_check #(
        .BASE_ADDR  (START_ADDR_P),
        .SIZE_BYTES (MEM_BYTES)
    ) u_range_check (
        .address  (fetch_pc_q),
        .in_range (in_range)
    );

    // A new fetch launches whenever the memory output slot is free or being drained.
    assign issue = !redirect_valid && (!inflight_q || id_ready);

    // Out-of-range fetches never touch memory; the stale read data is masked below.
    assign imem_enable     = reset_n && issue && in_range;
    assign imem_address    = fetch_pc_q;
    assign imem_read_write = 1'b0;
    assign imem_data_in    = '0;

    assign if_valid = inflight_q && !redirect_valid;
    assign if_pc    = out_pc_q;
    assign if_fault = out_fault_q;
    assign if_instr = out_fault_q ? NOP_INSTR_P : imem_data_out;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        inflight_d  = inflight_q;
        out_pc_d    = out_pc_q;
        out_fault_d = out_fault_q;
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            inflight_d = 1'b0;
        end else if (issue) begin
            inflight_d  = 1'b1;
            out_pc_d    = fetch_pc_q;
            out_fault_d = !in_range;
            fetch_pc_d  = fetch_pc_q + INSTR_BYTES;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q  <= START_ADDR_P;
            inflight_q  <= 1'b0;
            out_pc_q    <= '0;
            out_fault_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            inflight_q  <= inflight_d;
            out_pc_q    <= out_pc_d;
            out_fault_q <= out_fault_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: tasks push expected beats, a negedge monitor
// pops and compares every accepted beat; tasks also check control outputs inline.
module tb_fetch_stage;

    localparam logic [31:0] START = 32'h0100_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_fault;
    logic [31:0] imem_address;
    logic        imem_enable;
    logic        imem_read_write;
    logic [31:0] imem_data_in;
    logic [31:0] imem_data_out;

    logic [31:0] mem [0:1023];
    beat_t       sb_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    fetch_stage dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_ready        (id_ready),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .if_fault        (if_fault),
        .imem_address    (imem_address),
        .imem_enable     (imem_enable),
        .imem_read_write (imem_read_write),
        .imem_data_in    (imem_data_in),
        .imem_data_out   (imem_data_out)
    );

    always #5 clock = ~clock;

    // Synchronous memory: data appears the cycle after an enabled read, otherwise holds.
    initial imem_data_out = 32'hDEAD_BEEF;
    always @(posedge clock) begin
        if (imem_enable) begin
            logic [31:0] off;
            off = imem_address - START;
            imem_data_out <= mem[off[11:2]];
        end
    end

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - START;
        return 32'h0000_00A0 + {22'd0, off[11:2]};
    endfunction

    // Handshake completes at the next posedge; inputs only change just after posedges.
    always @(negedge clock) begin
        if (reset_n && if_valid && id_ready) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_beat: got pc=%h instr=%h fault=%0b, expected no beat",
                         if_pc, if_instr, if_fault);
            end else begin
                beat_t e;
                e = sb_q.pop_front();
                if (if_pc !== e.pc || if_instr !== e.instr || if_fault !== e.fault) begin
                    miscompares++;
                    $display("FAIL beat: got pc=%h instr=%h fault=%0b, expected pc=%h instr=%h fault=%0b",
                             if_pc, if_instr, if_fault, e.pc, e.instr, e.fault);
                end else begin
                    $display("beat ok pc=%h instr=%h fault=%0b", if_pc, if_instr, if_fault);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
        beat_t b;
        b.pc = pc;
        b.instr = instr;
        b.fault = fault;
        sb_q.push_back(b);
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d beats outstanding, expected 0", name, sb_q.size());
            sb_q.delete();
        end else begin
            $display("%s: scoreboard drained", name);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b1;
        repeat (2) step();
        @(negedge clock);
        vectors++;
        if (if_valid !== 1'b0 || imem_enable !== 1'b0 || imem_address !== START ||
            if_pc !== 32'd0 || if_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%0b en=%0b addr=%h pc=%h fault=%0b, expected 0 0 %h 0 0",
                     if_valid, imem_enable, imem_address, if_pc, if_fault, START);
        end else $display("reset: state ok");
        vectors++;
        if (imem_read_write !== 1'b0 || imem_data_in !== 32'd0) begin
            miscompares++;
            $display("FAIL tie_offs: got rw=%0b din=%h, expected 0 00000000", imem_read_write, imem_data_in);
        end else $display("reset: tie-offs ok");
    endtask

    task automatic test_stream();
        do_reset();
        id_ready = 1'b1;
        push(START,        32'hA0, 1'b0);
        push(START + 4,    32'hA1, 1'b0);
        push(START + 8,    32'hA2, 1'b0);
        repeat (4) step();
        id_ready = 1'b0;
        check_drained("stream");
    endtask

    task automatic test_stall();
        do_reset();
        id_ready = 1'b1;
        push(START, 32'hA0, 1'b0);
        repeat (2) step();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            vectors++;
            if (if_valid !== 1'b1 || if_pc !== START + 4 || if_instr !== 32'hA1 || imem_enable !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold: got valid=%0b pc=%h instr=%h en=%0b, expected 1 %h 000000a1 0",
                         if_valid, if_pc, if_instr, imem_enable, START + 4);
            end else $display("stall cycle %0d: held pc=%h", i, if_pc);
            step();
        end
        id_ready = 1'b1;
        push(START + 4, 32'hA1, 1'b0);
        push(START + 8, 32'hA2, 1'b0);
        repeat (2) step();
        id_ready = 1'b0;
        check_drained("stall");
    endtask

    task automatic test_redirect();
        do_reset();
        id_ready = 1'b1;
        push(START,     32'hA0, 1'b0);
        push(START + 4, 32'hA1, 1'b0);
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc = START + 32'h100;
        @(negedge clock);
        vectors++;
        if (if_valid !== 1'b0 || imem_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_kill: got valid=%0b en=%0b, expected 0 0", if_valid, imem_enable);
        end else $display("redirect: presented pc=%h killed", if_pc);
        step();
        redirect_valid = 1'b0;
        push(START + 32'h100, word_at(START + 32'h100), 1'b0);
        @(negedge clock);
        vectors++;
        if (imem_address !== START + 32'h100 || imem_enable !== 1'b1 || if_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_fetch: got addr=%h en=%0b valid=%0b, expected %h 1 0",
                     imem_address, imem_enable, if_valid, START + 32'h100);
        end else $display("redirect: fetching %h", imem_address);
        repeat (2) step();
        id_ready = 1'b0;
        check_drained("redirect");
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1;
        redirect_pc = START + 32'h102;
        id_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        push(START + 32'h100, word_at(START + 32'h100), 1'b0);
        @(negedge clock);
        vectors++;
        if (imem_address !== START + 32'h100) begin
            miscompares++;
            $display("FAIL misaligned_addr: got %h, expected %h", imem_address, START + 32'h100);
        end else $display("misaligned: fetching %h", imem_address);
        repeat (2) step();
        id_ready = 1'b0;
        check_drained("misaligned");
    endtask

    task automatic test_boundary();
        redirect_valid = 1'b1;
        redirect_pc = START + 32'hFFC;
        step();
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        push(START + 32'hFFC,  word_at(START + 32'hFFC), 1'b0);
        push(START + 32'h1000, NOP, 1'b1);
        step();
        @(negedge clock);
        vectors++;
        if (imem_address !== START + 32'h1000 || imem_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL oob_enable: got addr=%h en=%0b, expected %h 0", imem_address, imem_enable, START + 32'h1000);
        end else $display("boundary: %h not enabled", imem_address);
        repeat (2) step();
        id_ready = 1'b0;
        check_drained("boundary");

        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        push(32'h0, NOP, 1'b1);
        @(negedge clock);
        vectors++;
        if (imem_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL low_enable: got en=%0b, expected 0", imem_enable);
        end else $display("boundary: address 0 not enabled");
        repeat (2) step();
        id_ready = 1'b0;
        check_drained("low_addr");

        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        push(32'hFFFF_FFFC, NOP, 1'b1);
        push(32'h0000_0000, NOP, 1'b1);
        repeat (3) step();
        id_ready = 1'b0;
        check_drained("wrap");
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        id_ready = 1'b1;
        push(START, 32'hA0, 1'b0);
        repeat (2) step();
        id_ready = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        vectors++;
        if (if_valid !== 1'b0 || imem_enable !== 1'b0 || imem_address !== START) begin
            miscompares++;
            $display("FAIL async_reset: got valid=%0b en=%0b addr=%h, expected 0 0 %h",
                     if_valid, imem_enable, imem_address, START);
        end else $display("reset mid-stall: outputs cleared");
        step();
        reset_n = 1'b1;
        id_ready = 1'b1;
        push(START, 32'hA0, 1'b0);
        repeat (2) step();
        id_ready = 1'b0;
        check_drained("reset_mid_stall");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_00A0 + i;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misaligned();
        test_boundary();
        test_reset_mid_stall();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined RISC-V core. It owns the PC and drives the synchronous instruction memory, whose read data is valid one cycle after the address is presented. It presents {pc, instruction, fault} to decode over a valid/ready handshake at one instruction per cycle, and accepts branch/jump redirects from execute.

Parameters:
- START_ADDR, 32'h01000000, reset PC and base address of instruction memory.
- MEM_BYTES, 4096, instruction memory size in bytes; a fetch at or above START_ADDR+MEM_BYTES is out of range.
- NOP_INSTR, 32'h00000013, instruction delivered with a fault (addi x0,x0,0).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  redirect target.
- id_ready  in  1  decode accepts the presented instruction this cycle.
- if_valid  out  1  if_pc, if_instr and if_fault are valid.
- if_pc  out  32  PC of the presented instruction.
- if_instr  out  32  presented instruction.
- if_fault  out  1  fetch fault (out-of-range address); if_instr = NOP_INSTR.
- imem_address  out  32  byte address to instruction memory.
- imem_enable  out  1  memory read strobe.
- imem_read_write  out  1  tied 0 (read only).
- imem_data_in  out  32  tied 0.
- imem_data_out  in  32  memory read data, valid the cycle after the enabled read.

Behaviour:
- Registers:
  - fetch_pc: the address being presented.
  - inflight: memory output holds a live result.
  - out_pc: PC of that result.
  - out_fault: fault flag of that result.
  - imem_address = fetch_pc.
- Reset (async, reset_n=0), with imem_enable forced 0 while reset is asserted:
  - fetch_pc = START_ADDR
  - inflight = 0
  - out_pc = 0
  - out_fault = 0
  - if_valid = 0
- Definitions:
  - in_range = fetch_pc >= START_ADDR and fetch_pc - START_ADDR < MEM_BYTES.
  - issue = !redirect_valid && (!inflight || id_ready).
- Outputs:
  - imem_enable = issue && in_range.
  - if_valid = inflight && !redirect_valid. A redirect kills the presented instruction in the same cycle, and decode must ignore id_ready.
  - if_pc = out_pc.
  - if_fault = out_fault.
  - if_instr = out_fault ? NOP_INSTR : imem_data_out.
- On issue:
  - inflight <= 1
  - out_pc <= fetch_pc
  - out_fault <= !in_range
  - fetch_pc <= fetch_pc + 4, with 32-bit modulo wrap; 0xFFFFFFFC -> 0, which is out of range and faults.
- Stall: when inflight && !id_ready && !redirect_valid, no issue occurs. imem_enable = 0, so the memory output register holds, and all registers hold. Outputs must stay stable until accepted.
- Redirect has priority over issue and stall:
  - imem_enable = 0
  - inflight <= 0
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; low bits are dropped because misalignment is trapped by execute.
  - Penalty: redirect in cycle T, target issued in T+1, if_valid with target in T+2.
- Out-of-range fetch: memory is not enabled, and the stale imem_data_out is masked. The stage produces one if_fault beat per faulting PC and keeps incrementing. Decode/trap logic redirects.
- Throughput: 1 instr/cycle with id_ready held high. First if_valid occurs in the 2nd rising edge after reset_n deasserts.
- Reset mid-stall or mid-redirect: all state returns to reset values immediately. The first fetch after release is at START_ADDR.

Decomposition:
- Shared package (core-wide constants):
  - START_ADDR
  - NOP_INSTR
  - INSTR_BYTES = 4
  - XLEN = 32
- One small combinational sub-module, fetch_range_check: input address, outputs in_range. It is reused by the data-side memory stage later.
- The rest is flat in fetch_stage.

Test Plan:
- Reset release, id_ready=1 for 4 cycles, memory words 0xA0, 0xA1, 0xA2 -> if_pc = 0x01000000, 0x01000004, 0x01000008 on consecutive cycles, if_instr matching, if_fault=0.
- Stall: id_ready=0 for 3 cycles while if_pc = 0x01000004 -> if_valid, if_pc and if_instr stable; imem_enable=0 throughout. Release -> next beat 0x01000008, no duplicate or skipped PC.
- Redirect: redirect_valid=1 with redirect_pc = 0x01000100 while 0x01000008 is presented -> if_valid=0 that cycle; imem_address = 0x01000100 next cycle; if_pc = 0x01000100 two cycles after the redirect.
- Misaligned redirect to 0x01000102 -> fetch at 0x01000100.
- Redirect to 0x01000FFC with MEM_BYTES=4096 -> beat 0x01000FFC valid with fault=0. Next beat 0x01001000 has if_fault=1, if_instr = 0x00000013, and imem_enable=0 on that fetch. Redirect to 0x00000000 -> fault.
- reset_n pulsed low during a stall -> if_valid drops asynchronously; after release, first beat is if_pc = 0x01000000.
